// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the write-back arbiter slice.
//   XLEN        data path width
//   REG_ADDR_W  register address width
//   NUM_REGS    number of architectural registers
//   wb_entry_t  one buffered write-back: destination register + value
package wb_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_entry_t used to buffer long-latency results.
// Ports:
//   clk, reset   clock (rising edge), synchronous active-high reset
//   push         write push_entry at the clock edge (ignored when full)
//   push_entry   entry to store
//   pop          remove head at the clock edge (ignored when empty)
//   head         current oldest entry (valid when !empty)
//   full, empty  occupancy flags derived from the registered count
//   count        number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  wb_entry_t                  push_entry,
   input  logic                       pop,
   output wb_entry_t                  head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   wb_entry_t       mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: drives the single register-file write port from the ALU path
// (fixed priority, no backpressure) and a buffered long-latency result path.
// Also holds the pending-write scoreboard queried by decode and a starvation
// counter that requests a one-cycle ALU stall for the buffered head.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data       single-cycle ALU result
//   ll_issue/ll_issue_rd            long-latency op issued (marks rd pending)
//   ll_res_valid/ready/rd/data      long-latency result handshake
//   q1_addr/q1_busy, q2_addr/q2_busy scoreboard queries
//   stall_req                       upstream must hold alu_valid low next cycle
//   wr_addr/wr_data/write_en        register file write port
// Build option: define WB_BYPASS_EN to let an incoming result write straight
// through in the same cycle when the FIFO is empty and the ALU is not writing.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   input  logic                  ll_issue,
   input  logic [REG_ADDR_W-1:0] ll_issue_rd,
   input  logic                  ll_res_valid,
   output logic                  ll_res_ready,
   input  logic [REG_ADDR_W-1:0] ll_res_rd,
   input  logic [XLEN-1:0]       ll_res_data,
   input  logic [REG_ADDR_W-1:0] q1_addr,
   input  logic [REG_ADDR_W-1:0] q2_addr,
   output logic                  q1_busy,
   output logic                  q2_busy,
   output logic                  stall_req,
   output logic [REG_ADDR_W-1:0] wr_addr,
   output logic [XLEN-1:0]       wr_data,
   output logic                  write_en
);

   localparam int CW  = $clog2(FIFO_DEPTH) + 1;
   localparam int SCW = $clog2(STARVE_LIMIT + 2);
   localparam logic [SCW-1:0] LIMIT = SCW'(STARVE_LIMIT);

   wb_entry_t             fifo_head;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [CW-1:0]         fifo_count;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  alu_sel;
   logic                  byp_sel;
   logic [NUM_REGS-1:0]   busy_q;
   logic [NUM_REGS-1:0]   busy_d;
   logic [SCW-1:0]        starve_cnt;
   logic [SCW-1:0]        starve_d;

   // Result handshake: a result transfers on a rising edge where
   // ll_res_valid && ll_res_ready. The producer keeps valid/rd/data stable
   // until then. ready depends only on registered FIFO occupancy (never on
   // valid), so a full FIFO refuses the result even if the head pops this
   // cycle.
   assign ll_res_ready = !reset && !fifo_full;

   assign alu_sel  = !reset && alu_valid && (alu_rd != '0);
   assign fifo_pop = !reset && !alu_sel && !fifo_empty;

`ifdef WB_BYPASS_EN
   // Empty FIFO and idle write port: the incoming result takes the port now.
   assign byp_sel = !reset && !alu_sel && fifo_empty && ll_res_valid;
`else
   assign byp_sel = 1'b0;
`endif

   assign fifo_push = ll_res_valid && ll_res_ready && !byp_sel;

   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (fifo_push),
      .push_entry ('{rd: ll_res_rd, data: ll_res_data}),
      .pop        (fifo_pop),
      .head       (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (fifo_count)
   );

   // Write port mux. x0 targets are consumed without asserting write_en.
   always_comb begin
      write_en = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      if (alu_sel) begin
         write_en = 1'b1;
         wr_addr  = alu_rd;
         wr_data  = alu_data;
      end else if (fifo_pop) begin
         if (fifo_head.rd != '0) begin
            write_en = 1'b1;
            wr_addr  = fifo_head.rd;
            wr_data  = fifo_head.data;
         end
      end else if (byp_sel && (ll_res_rd != '0)) begin
         write_en = 1'b1;
         wr_addr  = ll_res_rd;
         wr_data  = ll_res_data;
      end
   end

   // Scoreboard: clears applied before the set so a same-cycle set wins.
   always_comb begin
      busy_d = busy_q;
      if (fifo_pop) begin
         busy_d[fifo_head.rd] = 1'b0;
      end
      if (byp_sel) begin
         busy_d[ll_res_rd] = 1'b0;
      end
      if (ll_issue) begin
         busy_d[ll_issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   assign q1_busy = busy_q[q1_addr];
   assign q2_busy = busy_q[q2_addr];

   // Consecutive cycles the head has been passed over. Saturates one above
   // the limit so a stall request fires only once per starvation episode.
   always_comb begin
      starve_d = '0;
      if (!fifo_empty && !fifo_pop) begin
         starve_d = (starve_cnt > LIMIT) ? starve_cnt : starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q     <= '0;
         starve_cnt <= '0;
         stall_req  <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         starve_cnt <= starve_d;
         stall_req  <= (starve_d == LIMIT);
      end
   end

   // An issue may only target a register that is free, or one being
   // released by a write in this same cycle.
   a_issue_not_busy: assert property (@(posedge clk) disable iff (reset)
      (ll_issue && (ll_issue_rd != '0)) |->
         (!busy_q[ll_issue_rd] ||
          (fifo_pop && (fifo_head.rd == ll_issue_rd)) ||
          (byp_sel && (ll_res_rd == ll_issue_rd))))
      else $error("ll_issue to busy register %0d", ll_issue_rd);

   // An ALU result that ignores stall_req still owns the write port.
   a_alu_wins_stall: assert property (@(posedge clk) disable iff (reset)
      (stall_req && alu_valid && (alu_rd != '0)) |->
         (write_en && (wr_addr == alu_rd)))
      else $error("ALU lost the write port during stall_req");

   a_count_range: assert property (@(posedge clk) disable iff (reset)
      fifo_count <= CW'(FIFO_DEPTH))
      else $error("FIFO count out of range");

endmodule
